// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C bus initiator: START, address+R/W, ACK check, one data byte, STOP
module i2c_master #(
  parameter int CLK_DIV   = 4,
  parameter int Data_size = 8,
  parameter int Addr_size = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_rw,
  input  logic [Addr_size-1:0] i_addr,
  input  logic [Data_size-1:0] i_data,
  output logic                 o_scl,
  inout  wire                  io_sda,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ack_err,
  output logic [Data_size-1:0] o_data
);

  localparam int AW   = Addr_size + 1;
  localparam int BMAX = (AW > Data_size) ? AW : Data_size;
  localparam int CW   = $clog2(BMAX + 1);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(Data_size - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_ADDR      = 4'd2;
  localparam logic [3:0] S_ADDR_ACK  = 4'd3;
  localparam logic [3:0] S_WRITE     = 4'd4;
  localparam logic [3:0] S_WRITE_ACK = 4'd5;
  localparam logic [3:0] S_READ      = 4'd6;
  localparam logic [3:0] S_MNACK     = 4'd7;
  localparam logic [3:0] S_STOP      = 4'd8;

  logic [3:0]           state, state_nxt;
  logic [1:0]           qtr, qtr_nxt;
  logic [DW-1:0]        div_cnt;
  logic [CW-1:0]        bit_cnt, bit_nxt;
  logic [AW-1:0]        addr_sh, addr_nxt;
  logic [Data_size-1:0] data_sh, data_nxt;
  logic [Data_size-1:0] rx_sh;
  logic                 rw_q;
  logic                 ack_q;
  logic                 scl_q, scl_nxt;
  logic                 sda_low, low_nxt;
  logic                 busy, done, ack_err;
  logic [Data_size-1:0] data_q;
  logic                 accept, tick, slot_end, sample;
  logic                 sda_in;

  assign io_sda    = sda_low ? 1'b0 : 1'bz;
  assign sda_in    = io_sda;
  assign o_scl     = scl_q;
  assign o_busy    = busy;
  assign o_done    = done;
  assign o_ack_err = ack_err;
  assign o_data    = data_q;

  assign tick     = busy && (div_cnt == DIV_LAST);
  assign slot_end = tick && (qtr == 2'd3);
  assign sample   = tick && (qtr == 2'd1);

  // Requests arriving while o_done is high are dropped so a new transfer starts one cycle later.
  always_comb begin
    accept    = (state == S_IDLE) && i_start && !done;
    state_nxt = state;
    qtr_nxt   = qtr;
    bit_nxt   = bit_cnt;
    addr_nxt  = addr_sh;
    data_nxt  = data_sh;
    if (accept) begin
      state_nxt = S_START;
      qtr_nxt   = 2'd0;
      bit_nxt   = '0;
      addr_nxt  = {i_addr, i_rw};
      data_nxt  = i_data;
    end else if (tick) begin
      qtr_nxt = qtr + 2'd1;
      if (qtr == 2'd3) begin
        case (state)
          S_START: begin
            state_nxt = S_ADDR;
            bit_nxt   = '0;
          end
          S_ADDR: begin
            addr_nxt = addr_sh << 1;
            if (bit_cnt == ADDR_LAST) begin
              state_nxt = S_ADDR_ACK;
              bit_nxt   = '0;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
          S_ADDR_ACK: begin
            bit_nxt = '0;
            if (ack_q)     state_nxt = S_STOP;
            else if (rw_q) state_nxt = S_READ;
            else           state_nxt = S_WRITE;
          end
          S_WRITE: begin
            data_nxt = data_sh << 1;
            if (bit_cnt == DATA_LAST) begin
              state_nxt = S_WRITE_ACK;
              bit_nxt   = '0;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
          S_WRITE_ACK: state_nxt = S_STOP;
          S_READ: begin
            if (bit_cnt == DATA_LAST) begin
              state_nxt = S_MNACK;
              bit_nxt   = '0;
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end
          S_MNACK: state_nxt = S_STOP;
          S_STOP:  state_nxt = S_IDLE;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Pin levels are decoded from the upcoming state so the pins themselves come straight from flops.
  always_comb begin
    scl_nxt = 1'b1;
    low_nxt = 1'b0;
    case (state_nxt)
      S_IDLE: begin
        scl_nxt = 1'b1;
        low_nxt = 1'b0;
      end
      S_START: begin
        scl_nxt = qtr_nxt[0] ^ qtr_nxt[1];
        low_nxt = qtr_nxt[1];
      end
      S_ADDR: begin
        scl_nxt = qtr_nxt[0] ^ qtr_nxt[1];
        low_nxt = ~addr_nxt[AW-1];
      end
      S_WRITE: begin
        scl_nxt = qtr_nxt[0] ^ qtr_nxt[1];
        low_nxt = ~data_nxt[Data_size-1];
      end
      S_STOP: begin
        scl_nxt = (qtr_nxt != 2'd0);
        low_nxt = ~qtr_nxt[1];
      end
      default: begin
        scl_nxt = qtr_nxt[0] ^ qtr_nxt[1];
        low_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      qtr     <= 2'd0;
      div_cnt <= '0;
      bit_cnt <= '0;
      addr_sh <= '0;
      data_sh <= '0;
      rx_sh   <= '0;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_low <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      qtr     <= qtr_nxt;
      bit_cnt <= bit_nxt;
      addr_sh <= addr_nxt;
      data_sh <= data_nxt;
      scl_q   <= scl_nxt;
      sda_low <= low_nxt;
      done    <= 1'b0;
      if (accept) begin
        div_cnt <= '0;
        busy    <= 1'b1;
        ack_err <= 1'b0;
        rw_q    <= i_rw;
      end else if (busy) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
      if (sample && (state == S_ADDR_ACK || state == S_WRITE_ACK)) begin
        ack_q <= sda_in;
        if (sda_in) ack_err <= 1'b1;
      end
      if (sample && state == S_READ) begin
        rx_sh <= (rx_sh << 1) | Data_size'(sda_in);
      end
      if (slot_end && state == S_MNACK) begin
        data_q <= rx_sh;
      end
      if (slot_end && state == S_STOP) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - table-driven bench for i2c_master with bus monitor, slave model and scoreboard
module tb_i2c_master;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic       i_rw;
  logic [6:0] i_addr;
  logic [7:0] i_data;
  logic       o_scl;
  wire        sda_bus;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_err;
  logic [7:0] o_data;

  i2c_master #(.CLK_DIV(4), .Data_size(8), .Addr_size(7)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_rw      (i_rw),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_scl     (o_scl),
    .io_sda    (sda_bus),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_ack_err (o_ack_err),
    .o_data    (o_data)
  );

  logic slv_low;
  pullup (sda_bus);
  assign sda_bus = slv_low ? 1'b0 : 1'bz;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] sbyte;
    logic       aack;
    logic       dack;
    logic       poke;
    logic       chain;
    int         lat;
    logic       err;
    logic [7:0] dout;
    int         nw;
    logic [8:0] w0;
    logic [8:0] w1;
  } vec_t;

  vec_t vt [6];
  vec_t exp_q [$];

  int n_vec = 0;
  int n_bad = 0;

  // Slave model and bus monitor state
  logic       slv_rw, slv_aack, slv_dack;
  logic [7:0] slv_byte;
  int         bit_idx = 100;
  logic [8:0] mon_sh;
  logic [8:0] mon_words [$];
  int         start_cnt = 0;
  int         stop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge sda_bus);
      if (o_scl === 1'b1) begin
        start_cnt++;
        bit_idx = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sda_bus);
      if (o_scl === 1'b1) stop_cnt++;
    end
  end

  initial begin
    mon_sh = '0;
    forever begin
      @(posedge o_scl);
      mon_sh = {mon_sh[7:0], sda_bus};
      bit_idx++;
      if (bit_idx == 9 || bit_idx == 18) mon_words.push_back(mon_sh);
    end
  end

  // The slave only moves SDA while SCL is low.
  initial begin
    slv_low = 1'b0;
    forever begin
      @(negedge o_scl);
      slv_low = 1'b0;
      if (bit_idx == 8)
        slv_low = slv_aack;
      else if (slv_rw && slv_aack && bit_idx >= 9 && bit_idx <= 16)
        slv_low = ~slv_byte[16 - bit_idx];
      else if (!slv_rw && slv_aack && bit_idx == 17)
        slv_low = slv_dack;
    end
  end

  task automatic launch(input vec_t v);
    i_rw      = v.rw;
    i_addr    = v.addr;
    i_data    = v.data;
    slv_rw    = v.rw;
    slv_aack  = v.aack;
    slv_dack  = v.dack;
    slv_byte  = v.sbyte;
    mon_words.delete();
    start_cnt = 0;
    stop_cnt  = 0;
    i_start   = 1'b1;
  endtask

  initial begin
    vec_t v, e;
    int   k;
    logic got;
    logic chained;
    int   done_seen;

    //        rw    addr   data   sbyte  aack  dack  poke  chain lat  err   dout   nw  w0      w1
    vt[0] = '{1'b0, 7'h50, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 320, 1'b0, 8'h00, 2, 9'h140, 9'h14A};
    vt[1] = '{1'b1, 7'h3C, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 320, 1'b0, 8'h5A, 2, 9'h0F2, 9'h0B5};
    vt[2] = '{1'b0, 7'h22, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 176, 1'b1, 8'h5A, 1, 9'h089, 9'h000};
    vt[3] = '{1'b0, 7'h50, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 320, 1'b1, 8'h5A, 2, 9'h140, 9'h1FF};
    vt[4] = '{1'b1, 7'h11, 8'h00, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 320, 1'b0, 8'hC3, 2, 9'h046, 9'h187};
    vt[5] = '{1'b1, 7'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 176, 1'b1, 8'hC3, 1, 9'h0F3, 9'h000};

    i_rst = 1'b1; i_start = 1'b0; i_rw = 1'b0; i_addr = '0; i_data = '0;
    slv_rw = 1'b0; slv_aack = 1'b0; slv_dack = 1'b0; slv_byte = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_scl", o_scl, 1);
    chk("rst_sda", sda_bus, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ack_err", o_ack_err, 0);
    chk("rst_data", o_data, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Abort during the third address bit (address byte 0x80: that bit drives SDA low).
    v = vt[0];
    v.addr = 7'h40;
    launch(v);
    @(negedge i_clk);
    i_start = 1'b0;
    chk("abort_busy_on", o_busy, 1);
    repeat (60) @(negedge i_clk);
    chk("abort_scl_pre", o_scl, 0);
    chk("abort_sda_pre", sda_bus, 0);
    i_rst = 1'b1;
    #1;
    chk("abort_scl", o_scl, 1);
    chk("abort_sda", sda_bus, 1);
    chk("abort_busy", o_busy, 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge i_clk);
      if (o_done) done_seen++;
    end
    i_rst = 1'b0;
    repeat (200) begin
      @(negedge i_clk);
      if (o_done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle_busy", o_busy, 0);

    chained = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      if (!chained) launch(v);
      @(negedge i_clk);
      chk($sformatf("v%0d_busy_on", i), o_busy, 1);
      chk($sformatf("v%0d_err_clr", i), o_ack_err, 0);
      i_start = 1'b0;
      exp_q.push_back(v);

      k = 0;
      got = 1'b0;
      while (!got && k < 1000) begin
        @(negedge i_clk);
        k++;
        if (v.poke && k == 50) begin
          i_start = 1'b1;
          i_addr  = 7'h7F;
          i_rw    = ~v.rw;
        end
        if (v.poke && k == 51) i_start = 1'b0;
        if (o_done) got = 1'b1;
      end
      chk($sformatf("v%0d_done_seen", i), got, 1);

      e = exp_q.pop_front();
      chk($sformatf("v%0d_latency", i), k, e.lat);
      chk($sformatf("v%0d_ack_err", i), o_ack_err, e.err);
      chk($sformatf("v%0d_data", i), o_data, e.dout);
      chk($sformatf("v%0d_busy_off", i), o_busy, 0);
      chk($sformatf("v%0d_starts", i), start_cnt, 1);
      chk($sformatf("v%0d_stops", i), stop_cnt, 1);
      chk($sformatf("v%0d_nwords", i), mon_words.size(), e.nw);
      chk($sformatf("v%0d_w0", i), (mon_words.size() > 0) ? {23'b0, mon_words[0]} : 32'hDEADBEEF, e.w0);
      if (e.nw == 2)
        chk($sformatf("v%0d_w1", i), (mon_words.size() > 1) ? {23'b0, mon_words[1]} : 32'hDEADBEEF, e.w1);

      chained = v.chain;
      if (chained) launch(vt[i+1]);
      @(negedge i_clk);
      chk($sformatf("v%0d_done_pulse", i), o_done, 0);
      if (chained) chk($sformatf("v%0d_ignore_on_done", i), o_busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
